// File: rtl/lvt_port_scheduler_if.sv
// Requester / memory-port bundle for lvt_port_scheduler.
//   slave  : the scheduler (takes requests and mem_q, drives grants, responses, memory ports)
//   master : the environment (requesters plus the LVT memory model)
// Signals:
//   req_valid/req_we/req_addr/req_data : per-requester request
//   req_ready                          : per-requester grant
//   resp_valid/resp_data               : per-requester read response
//   mem_addr/mem_en/mem_d/mem_q        : per-port memory interface
interface lvt_port_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int PORTS = 4,
  parameter int REQS  = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [REQS-1:0]             req_valid;
  logic [REQS-1:0]             req_we;
  logic [REQS-1:0][AW-1:0]     req_addr;
  logic [REQS-1:0][WIDTH-1:0]  req_data;
  logic [REQS-1:0]             req_ready;
  logic [REQS-1:0]             resp_valid;
  logic [REQS-1:0][WIDTH-1:0]  resp_data;
  logic [PORTS-1:0][AW-1:0]    mem_addr;
  logic [PORTS-1:0]            mem_en;
  logic [PORTS-1:0][WIDTH-1:0] mem_d;
  logic [PORTS-1:0][WIDTH-1:0] mem_q;

  modport slave (
    input  req_valid, req_we, req_addr, req_data, mem_q,
    output req_ready, resp_valid, resp_data, mem_addr, mem_en, mem_d
  );

  modport master (
    output req_valid, req_we, req_addr, req_data, mem_q,
    input  req_ready, resp_valid, resp_data, mem_addr, mem_en, mem_d
  );
endinterface

// File: rtl/lvt_port_scheduler.sv
// Round-robin scheduler mapping REQS requesters onto PORTS ports of a
// multi-ported LVT memory.
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset
//   bus : lvt_port_scheduler_if.slave (requests, grants, responses, memory ports)
// Each cycle requesters are scanned from rr_ptr; the k-th grant in scan order
// takes port k. Only the first writer to a given address is granted in a cycle.
// Reads are tracked per port for RD_LAT cycles, then mem_q of that port is
// steered to the owning requester as a one-cycle response.
module lvt_port_scheduler #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int PORTS  = 4,
  parameter int REQS   = 8,
  parameter int RD_LAT = 1
) (
  input logic                 clk,
  input logic                 rst,
  lvt_port_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(REQS);

  logic [RW-1:0]             rr_ptr;
  logic [RW-1:0]             rr_nxt;
  logic [REQS-1:0]           grant;
  logic [PORTS-1:0]          port_use;
  logic [PORTS-1:0][RW-1:0]  port_id;
  logic [PORTS-1:0]          rd_launch;

  // Read tracking: stage s holds reads granted s cycles ago, per port.
  logic [RD_LAT:1][PORTS-1:0]         vld_pipe;
  logic [RD_LAT:1][PORTS-1:0][RW-1:0] id_pipe;

  // Scan from rr_ptr; wr_seen remembers addresses already claimed by a
  // granted writer this cycle so a later writer to the same address waits.
  always_comb begin
    logic [2**AW-1:0] wr_seen;
    logic [RW-1:0]    idx;
    int               cnt;
    grant    = '0;
    port_use = '0;
    port_id  = '0;
    rr_nxt   = rr_ptr;
    wr_seen  = '0;
    cnt      = 0;
    idx      = '0;
    for (int k = 0; k < REQS; k++) begin
      idx = RW'((int'(rr_ptr) + k) % REQS);
      if (bus.req_valid[idx] && cnt < PORTS &&
          !(bus.req_we[idx] && wr_seen[bus.req_addr[idx]])) begin
        grant[idx]    = 1'b1;
        port_use[cnt] = 1'b1;
        port_id[cnt]  = idx;
        if (bus.req_we[idx]) wr_seen[bus.req_addr[idx]] = 1'b1;
        rr_nxt = (idx == RW'(REQS-1)) ? '0 : idx + 1'b1;
        cnt    = cnt + 1;
      end
    end
  end

  assign bus.req_ready = rst ? '0 : grant;

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic act, wr;
    assign act             = !rst && port_use[p];
    assign wr              = act && bus.req_we[port_id[p]];
    assign bus.mem_addr[p] = act ? bus.req_addr[port_id[p]] : '0;
    assign bus.mem_en[p]   = wr;
    assign bus.mem_d[p]    = wr ? bus.req_data[port_id[p]] : '0;
    assign rd_launch[p]    = act && !bus.req_we[port_id[p]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      rr_ptr      <= rr_nxt;
      vld_pipe[1] <= rd_launch;
      id_pipe[1]  <= port_id;
      for (int s = 2; s <= RD_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        id_pipe[s]  <= id_pipe[s-1];
      end
    end
  end

  // A requester holds at most one grant per cycle, so at most one port
  // targets each requester in the tail stage.
  always_comb begin
    bus.resp_valid = '0;
    bus.resp_data  = '0;
    if (!rst) begin
      for (int p = 0; p < PORTS; p++) begin
        if (vld_pipe[RD_LAT][p]) begin
          bus.resp_valid[id_pipe[RD_LAT][p]] = 1'b1;
          bus.resp_data[id_pipe[RD_LAT][p]]  = bus.mem_q[p];
        end
      end
    end
  end
endmodule
